// File: rtl/async_fifo.sv
// rtl/async_fifo.sv - Single-clock FIFO with Gray-coded pointers and optional pointer synchronizers
//
// Purpose:
//   First-word-fall-through FIFO built around binary and Gray read/write pointers.
//   The flags compare the Gray pointers. Optional 2-stage register chains on the
//   cross-side pointers model synchronizer latency, which makes both flags
//   conservative.
//
// Configuration macro:
//   ASYNC_FIFO_PTR_SYNC_EN - when defined, each cross-side Gray pointer passes
//                            through a 2-stage register chain before the flag
//                            compare.
//
// Parameters:
//   DATA_WIDTH - data word width in bits
//   MEM_DEPTH  - number of storage entries (power of two, >= 4)
//   ADD_WIDTH  - storage address width
//
// Ports:
//   clk      in   single clock, rising edge
//   rst      in   synchronous active-low reset
//   wr_data  in   write word, captured when a write is accepted
//   wr_inc   in   write request, one word per cycle
//   rd_inc   in   read request, pops one word per cycle
//   rd_data  out  head-of-FIFO word (combinational, zero latency)
//   full     out  MEM_DEPTH words held
//   empty    out  no words held

module async_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 16,
  parameter int ADD_WIDTH  = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_inc,
  input  logic                  rd_inc,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic [ADD_WIDTH:0] wbin_q,  wbin_d;
  logic [ADD_WIDTH:0] rbin_q,  rbin_d;
  logic [ADD_WIDTH:0] wgray_q, wgray_d;
  logic [ADD_WIDTH:0] rgray_q, rgray_d;

  // Pointers as observed by the opposite side.
  logic [ADD_WIDTH:0] wgray_seen;
  logic [ADD_WIDTH:0] rgray_seen;

  logic wr_acc;
  logic rd_acc;

  always_comb begin
    wr_acc  = wr_inc & ~full;
    rd_acc  = rd_inc & ~empty;
    wbin_d  = wbin_q + {{ADD_WIDTH{1'b0}}, wr_acc};
    rbin_d  = rbin_q + {{ADD_WIDTH{1'b0}}, rd_acc};
    wgray_d = wbin_d ^ (wbin_d >> 1);
    rgray_d = rbin_d ^ (rbin_d >> 1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wbin_q  <= '0;
      rbin_q  <= '0;
      wgray_q <= '0;
      rgray_q <= '0;
    end else begin
      wbin_q  <= wbin_d;
      rbin_q  <= rbin_d;
      wgray_q <= wgray_d;
      rgray_q <= rgray_d;
    end
  end

  // Storage is never cleared; reset only blocks the write in its own cycle.
  always_ff @(posedge clk) begin
    if (rst && wr_acc) begin
      mem_q[wbin_q[ADD_WIDTH-1:0]] <= wr_data;
    end
  end

`ifdef ASYNC_FIFO_PTR_SYNC_EN
  logic [ADD_WIDTH:0] wsync1_q, wsync2_q;
  logic [ADD_WIDTH:0] rsync1_q, rsync2_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wsync1_q <= '0;
      wsync2_q <= '0;
      rsync1_q <= '0;
      rsync2_q <= '0;
    end else begin
      wsync1_q <= wgray_q;
      wsync2_q <= wsync1_q;
      rsync1_q <= rgray_q;
      rsync2_q <= rsync1_q;
    end
  end

  assign wgray_seen = wsync2_q;
  assign rgray_seen = rsync2_q;
`else
  assign wgray_seen = wgray_q;
  assign rgray_seen = rgray_q;
`endif

  // In Gray code, "one full lap ahead" is the same value with the top two
  // bits inverted.
  assign empty   = (rgray_q == wgray_seen);
  assign full    = (wgray_q == {~rgray_seen[ADD_WIDTH:ADD_WIDTH-1],
                                rgray_seen[ADD_WIDTH-2:0]});
  assign rd_data = mem_q[rbin_q[ADD_WIDTH-1:0]];

endmodule

// File: tb/tb_async_fifo.sv
// tb/tb_async_fifo.sv - Self-checking bench for async_fifo

module tb_async_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
`ifdef ASYNC_FIFO_PTR_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_inc = 1'b0;
  logic          rd_inc = 1'b0;
  logic [DW-1:0] rd_data;
  logic          full;
  logic          empty;

  async_fifo #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_data (wr_data),
    .wr_inc  (wr_inc),
    .rd_inc  (rd_inc),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: a queue of held words plus total write/read counts.
  // Each side sees the other side's count as it was LAT edges ago.
  logic [DW-1:0] mq[$];
  int wcnt = 0, rcnt = 0;
  int wh1 = 0, wh2 = 0, rh1 = 0, rh2 = 0;

  function automatic int w_seen();
    return (LAT == 0) ? wcnt : wh2;
  endfunction

  function automatic int r_seen();
    return (LAT == 0) ? rcnt : rh2;
  endfunction

  function automatic logic m_empty();
    return (w_seen() == rcnt);
  endfunction

  function automatic logic m_full();
    return ((wcnt - r_seen()) == DEPTH);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge: drive inputs, compare pre-edge outputs with the
  // model, clock once, advance the model, return at the next negedge.
  task automatic step(input logic rn, input logic w, input logic r,
                      input logic [DW-1:0] d, input logic en);
    logic acc_w, acc_r;
    rst = rn; wr_inc = w; rd_inc = r; wr_data = d;
    #1;
    if (en) begin
      chk("model_empty", int'(empty), int'(m_empty()));
      chk("model_full", int'(full), int'(m_full()));
      if (!m_empty() && mq.size() > 0) chk("model_rd_data", int'(rd_data), int'(mq[0]));
    end
    acc_w = w && !m_full();
    acc_r = r && !m_empty();
    @(posedge clk);
    if (!rn) begin
      mq.delete();
      wcnt = 0; rcnt = 0; wh1 = 0; wh2 = 0; rh1 = 0; rh2 = 0;
    end else begin
      if (acc_r) void'(mq.pop_front());
      if (acc_w) mq.push_back(d);
      wh2 = wh1; wh1 = wcnt;
      rh2 = rh1; rh1 = rcnt;
      wcnt += int'(acc_w);
      rcnt += int'(acc_r);
    end
    @(negedge clk);
    rst = 1'b1; wr_inc = 1'b0; rd_inc = 1'b0;
  endtask

  task automatic settle();
    for (int i = 0; i < LAT; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b1);
  endtask

  typedef struct packed {
    logic          rn;
    logic          w;
    logic          r;
    logic [DW-1:0] d;
    logic          e;
    logic          f;
    logic          cd;
    logic [DW-1:0] ed;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 8'hAA, 1'b0, 1'b0, 1'b1, 8'hAA};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hAA};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hAA};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 8'h11};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 8'h11};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h22};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h33};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 8'h5A};

    @(negedge clk);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("reset_empty", int'(empty), 1);
    chk("reset_full", int'(full), 0);

    // Directed table; each vector is followed by the flag latency.
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].rn, tbl[i].w, tbl[i].r, tbl[i].d, 1'b1);
      settle();
      chk($sformatf("tbl%0d_empty", i), int'(empty), int'(tbl[i].e));
      chk($sformatf("tbl%0d_full", i), int'(full), int'(tbl[i].f));
      if (tbl[i].cd) chk($sformatf("tbl%0d_data", i), int'(rd_data), int'(tbl[i].ed));
    end

    // Fill to full, overflow write dropped, drain in order, underflow ignored.
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 1'b0, 8'(i), 1'b1);
    chk("fill_full", int'(full), 1);
    step(1'b1, 1'b1, 1'b0, 8'hBB, 1'b1);
    settle();
    chk("overflow_full", int'(full), 1);
    chk("overflow_empty", int'(empty), 0);
    rd_inc = 1'b1; #1;
    chk("first_read_data", int'(rd_data), 0);
    step(1'b1, 1'b0, 1'b1, '0, 1'b1);
    settle();
    chk("after_read_full", int'(full), 0);
    for (int i = 1; i < DEPTH; i++) begin
      #1;
      chk($sformatf("drain_data%0d", i), int'(rd_data), i);
      step(1'b1, 1'b0, 1'b1, '0, 1'b1);
    end
    settle();
    chk("drain_empty", int'(empty), 1);
    step(1'b1, 1'b0, 1'b1, '0, 1'b1);
    chk("underflow_empty", int'(empty), 1);
    chk("underflow_full", int'(full), 0);

    // 8 held, 40 simultaneous write/read cycles across pointer wrap.
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 8'(8'h80 + i), 1'b1);
    settle();
    for (int j = 0; j < 40; j++) begin
      #1;
      chk("stream_data", int'(rd_data), (j < 8) ? (8'h80 + j) : (8'h40 + j - 8));
      chk("stream_full", int'(full), 0);
      chk("stream_empty", int'(empty), 0);
      step(1'b1, 1'b1, 1'b1, 8'(8'h40 + j), 1'b1);
    end
    chk("stream_occupancy", mq.size(), 8);

    // Reset with 5 held discards them; a fresh write is what comes back.
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 8'(8'hC0 + i), 1'b1);
    step(1'b0, 1'b1, 1'b1, 8'hEE, 1'b1);
    chk("midreset_empty", int'(empty), 1);
    chk("midreset_full", int'(full), 0);
    step(1'b1, 1'b1, 1'b0, 8'h77, 1'b1);
    settle();
    chk("post_reset_data", int'(rd_data), 8'h77);
    step(1'b1, 1'b0, 1'b1, '0, 1'b1);
    settle();
    chk("post_reset_empty", int'(empty), 1);

    // Randomized traffic against the model, with write- and read-biased phases.
    for (int k = 0; k < 800; k++) begin
      logic rn, w, r;
      rn = ($urandom_range(149) != 0);
      if ((k / 100) % 2 == 0) begin
        w = ($urandom_range(3) != 0);
        r = ($urandom_range(3) == 0);
      end else begin
        w = ($urandom_range(3) == 0);
        r = ($urandom_range(3) != 0);
      end
      step(rn, w, r, 8'($urandom), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
